// File: rtl/tt_islam_ihfaz_logic_pkg.sv
// Shared encodings for the logic-sequencer tile: op codes, FSM states, output widths.
package tt_islam_ihfaz_logic_pkg;

    localparam int SIG_W = 8;
    localparam logic [7:0] UIO_OE_MASK = 8'hF8;

    localparam logic [2:0] OP_NAND  = 3'd0;
    localparam logic [2:0] OP_AND   = 3'd1;
    localparam logic [2:0] OP_NOR   = 3'd2;
    localparam logic [2:0] OP_OR    = 3'd3;
    localparam logic [2:0] OP_XOR   = 3'd4;
    localparam logic [2:0] OP_XNOR  = 3'd5;
    localparam logic [2:0] OP_NOTA  = 3'd6;
    localparam logic [2:0] OP_PASSA = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic [SIG_W-1:0] rotl1(input logic [SIG_W-1:0] v);
        return {v[SIG_W-2:0], v[SIG_W-1]};
    endfunction

endpackage

// File: rtl/tt_islam_ihfaz_logic_seq_if.sv
// Tiny Tapeout pin bundle; master drives the pads, slave is the tile.
// Handshake: none -- strobes on ui_in[6]/ui_in[7] are rising-edge events, results are level outputs.
interface tt_islam_ihfaz_logic_seq_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
    modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/tt_islam_ihfaz_logic_alu.sv
// Combinational WIDTH-bit bitwise logic unit selecting one of eight operations.
module tt_islam_ihfaz_logic_alu
    import tt_islam_ihfaz_logic_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    always_comb begin
        y = a;
        case (op)
            OP_NAND: y = ~(a & b);
            OP_AND:  y = a & b;
            OP_NOR:  y = ~(a | b);
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_NOTA: y = ~a;
            default: y = a;
        endcase
    end
endmodule

// File: rtl/tt_islam_ihfaz_logic_seq.sv
// Logic unit with load-captured result and an autonomous truth-table sweep signature.
// Optional input synchroniser: define TT_ISLAM_IHFAZ_INSYNC_EN.
module tt_islam_ihfaz_logic_seq
    import tt_islam_ihfaz_logic_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input logic                      clk,
    input logic                      rst_n,
    tt_islam_ihfaz_logic_seq_if.slave bus
);
    localparam int IDX_W = 2 * WIDTH;
    localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};

    logic [7:0] ui_s;
    logic [2:0] op_s;

`ifdef TT_ISLAM_IHFAZ_INSYNC_EN
    logic [10:0] sync_a, sync_b;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {bus.uio_in[2:0], bus.ui_in};
            sync_b <= sync_a;
        end
    end
    assign {op_s, ui_s} = sync_b;
`else
    assign ui_s = bus.ui_in;
    assign op_s = bus.uio_in[2:0];
`endif

    logic unused_bits;
    assign unused_bits = &{1'b0, bus.ena, bus.uio_in[7:3], ui_s};

    // History follows the pin even while reset is held, so a strobe already
    // high at reset release is not mistaken for a fresh edge.
    logic load_prev, sweep_prev;
    always_ff @(posedge clk) begin
        load_prev  <= ui_s[6];
        sweep_prev <= ui_s[7];
    end

    logic load_edge, sweep_edge;
    assign load_edge  = ui_s[6] & ~load_prev;
    assign sweep_edge = ui_s[7] & ~sweep_prev;

    state_t            state, state_next;
    logic              busy, done, sweeping;
    logic [IDX_W-1:0]  idx;
    logic [2:0]        op_q;
    logic [WIDTH-1:0]  result;
    logic [SIG_W-1:0]  signature;

    logic [2:0]        alu_op;
    logic [WIDTH-1:0]  alu_a, alu_b, alu_y;

    assign sweeping = (state == ST_SWEEP);
    assign alu_op   = sweeping ? op_q : op_s;
    assign alu_a    = sweeping ? idx[WIDTH-1:0] : ui_s[WIDTH-1:0];
    assign alu_b    = sweeping ? idx[IDX_W-1:WIDTH] : ui_s[WIDTH+2:3];

    tt_islam_ihfaz_logic_alu #(.WIDTH(WIDTH)) u_alu (
        .op (alu_op),
        .a  (alu_a),
        .b  (alu_b),
        .y  (alu_y)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (sweep_edge) state_next = ST_SWEEP;
            ST_SWEEP: if (idx == IDX_LAST) state_next = ST_DONE;
            ST_DONE: begin
                if (sweep_edge)     state_next = ST_SWEEP;
                else if (load_edge) state_next = ST_IDLE;
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_SWEEP);
        done = (state == ST_DONE);
        bus.uo_out  = done ? signature : {{(8 - WIDTH){1'b0}}, result};
        bus.uio_out = {busy, done, op_q, 3'b000};
        bus.uio_oe  = UIO_OE_MASK;
    end

    // Sweep takes priority over a coincident load edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result    <= '0;
            signature <= '0;
            idx       <= '0;
            op_q      <= '0;
        end else if (sweeping) begin
            signature <= rotl1(signature) ^ {{(SIG_W - WIDTH){1'b0}}, alu_y};
            result    <= alu_y;
            idx       <= idx + 1'b1;
        end else if (sweep_edge) begin
            op_q      <= op_s;
            idx       <= '0;
            signature <= '0;
        end else if (load_edge) begin
            op_q      <= op_s;
            result    <= alu_y;
        end
    end
endmodule

// File: tb/tb_tt_islam_ihfaz_logic_seq.sv
// Scoreboard bench: WIDTH=3 and WIDTH=1 instances, directed loads, sweeps and a mid-sweep reset.
module tb_tt_islam_ihfaz_logic_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tt_islam_ihfaz_logic_seq_if bus3 ();
    tt_islam_ihfaz_logic_seq_if bus1 ();

    tt_islam_ihfaz_logic_seq #(.WIDTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
    tt_islam_ihfaz_logic_seq #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int checks = 0;
    int errors = 0;

    logic [23:0] exp_q[$];
    int          dut_q[$];
    string       name_q[$];
    logic [15:0] done_exp_q[$];
    int          done_dut_q[$];
    logic        chk_req = 1'b0;

    logic [7:0] uo_v  [2];
    logic [7:0] uio_v [2];
    logic [7:0] oe_v  [2];
    assign uo_v[0]  = bus3.uo_out;
    assign uio_v[0] = bus3.uio_out;
    assign oe_v[0]  = bus3.uio_oe;
    assign uo_v[1]  = bus1.uo_out;
    assign uio_v[1] = bus1.uio_out;
    assign oe_v[1]  = bus1.uio_oe;

    function automatic logic [7:0] model_f(input logic [2:0] op, input int a, input int b, input int w);
        int m;
        int r;
        m = (1 << w) - 1;
        case (op)
            3'd0: r = ~(a & b);
            3'd1: r = a & b;
            3'd2: r = ~(a | b);
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~(a ^ b);
            3'd6: r = ~a;
            default: r = a;
        endcase
        return 8'(r & m);
    endfunction

    function automatic logic [7:0] model_sig(input int w, input logic [2:0] op);
        logic [7:0] s;
        int m;
        s = 8'h00;
        m = (1 << w) - 1;
        for (int i = 0; i < (1 << (2 * w)); i++)
            s = {s[6:0], s[7]} ^ model_f(op, i & m, (i >> w) & m, w);
        return s;
    endfunction

    // Monitor: snapshot compares on request, sweep results whenever done rises.
    int   busy_cnt  [2];
    logic prev_busy [2];
    logic prev_done [2];
    initial begin
        for (int d = 0; d < 2; d++) begin
            busy_cnt[d] = 0;
            prev_busy[d] = 1'b0;
            prev_done[d] = 1'b0;
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (uio_v[d][7]) busy_cnt[d] = prev_busy[d] ? busy_cnt[d] + 1 : 1;
            if (uio_v[d][6] && !prev_done[d]) begin
                checks++;
                if (done_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected dut%0d: sig=%02h busy=%0d", d, uo_v[d], busy_cnt[d]);
                end else begin
                    logic [15:0] e;
                    int ed;
                    e  = done_exp_q.pop_front();
                    ed = done_dut_q.pop_front();
                    if (ed != d || e != {busy_cnt[d][7:0], uo_v[d]}) begin
                        errors++;
                        $display("FAIL sweep_done dut%0d: got busy=%0d sig=%02h, want dut%0d busy=%0d sig=%02h",
                                 d, busy_cnt[d], uo_v[d], ed, e[15:8], e[7:0]);
                    end
                end
            end
            prev_busy[d] = uio_v[d][7];
            prev_done[d] = uio_v[d][6];
        end
        if (chk_req) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL snapshot_underflow: no expected value queued");
            end else begin
                logic [23:0] e;
                int d;
                string nm;
                e  = exp_q.pop_front();
                d  = dut_q.pop_front();
                nm = name_q.pop_front();
                if ({oe_v[d], uio_v[d], uo_v[d]} != e) begin
                    errors++;
                    $display("FAIL %s dut%0d: got oe=%02h uio=%02h uo=%02h, want oe=%02h uio=%02h uo=%02h",
                             nm, d, oe_v[d], uio_v[d], uo_v[d], e[23:16], e[15:8], e[7:0]);
                end
            end
        end
    end

    task automatic snap(input int d, input string nm, input logic [7:0] uo, input logic [7:0] uio);
        exp_q.push_back({8'hF8, uio, uo});
        dut_q.push_back(d);
        name_q.push_back(nm);
        chk_req = 1'b1;
        @(negedge clk);
        #1 chk_req = 1'b0;
    endtask

    task automatic expect_sweep(input int d, input logic [7:0] len, input logic [7:0] sig);
        done_exp_q.push_back({len, sig});
        done_dut_q.push_back(d);
    endtask

    task automatic wait_done(input int d, input int budget);
        int n;
        n = 0;
        while (!uio_v[d][6] && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!uio_v[d][6]) begin
            checks++;
            errors++;
            $display("FAIL wait_done_timeout dut%0d: done=0 after %0d cycles, want done=1", d, budget);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus3.ena = 1'b1;  bus1.ena = 1'b1;
        bus3.ui_in = 8'h40; bus1.ui_in = 8'h40;
        bus3.uio_in = 8'h00; bus1.uio_in = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        snap(0, "reset_state", 8'h00, 8'h00);
        snap(1, "reset_state", 8'h00, 8'h00);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        snap(0, "no_load_on_release", 8'h00, 8'h00);
        snap(1, "no_load_on_release", 8'h00, 8'h00);

        // NAND: A=101 B=011 -> 110
        @(negedge clk); bus3.ui_in = 8'h00; bus3.uio_in = 8'h00;
        @(negedge clk); bus3.ui_in = 8'h5D;
        settle();
        snap(0, "load_nand", 8'h06, 8'h00);

        // XOR: A=110 B=011 -> 101, then a held strobe must not re-capture
        @(negedge clk); bus3.ui_in = 8'h00; bus3.uio_in = 8'h04;
        @(negedge clk); bus3.ui_in = 8'h5E;
        settle();
        snap(0, "load_xor", 8'h05, 8'h20);
        bus3.ui_in = 8'h47; bus3.uio_in = 8'h01;
        repeat (5) @(posedge clk);
        #1;
        snap(0, "held_load_no_recapture", 8'h05, 8'h20);

        // WIDTH=1 NAND sweep: results 1,1,1,0 fold to 0x0E
        @(negedge clk); bus1.ui_in = 8'h00; bus1.uio_in = 8'h00;
        expect_sweep(1, 8'd4, 8'h0E);
        @(negedge clk); bus1.ui_in = 8'h80;
        wait_done(1, 20);
        settle();
        snap(1, "w1_done_hold", 8'h0E, 8'h40);
        @(negedge clk); bus1.uio_in = 8'h01; bus1.ui_in = 8'hC9;
        settle();
        snap(1, "w1_load_leaves_done", 8'h01, 8'h08);

        // Coincident load+sweep edges; mid-sweep op change and load edge ignored
        @(negedge clk); bus3.ui_in = 8'h00; bus3.uio_in = 8'h04;
        expect_sweep(0, 8'd64, model_sig(3, 3'd4));
        @(negedge clk); bus3.ui_in = 8'hDD;
        repeat (5) @(posedge clk);
        @(negedge clk); bus3.uio_in = 8'h02; bus3.ui_in = 8'h80;
        @(negedge clk); bus3.ui_in = 8'hC0;
        wait_done(0, 200);
        settle();
        snap(0, "w3_sweep_xor_done", model_sig(3, 3'd4), 8'h60);

        // Reset at sweep cycle 10 aborts cleanly; a fresh sweep then completes
        @(negedge clk); bus3.ui_in = 8'h00; bus3.uio_in = 8'h05;
        @(negedge clk); bus3.ui_in = 8'h80;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        settle();
        snap(0, "reset_mid_sweep", 8'h00, 8'h00);
        rst_n = 1'b1;
        @(negedge clk); bus3.ui_in = 8'h00; bus3.uio_in = 8'h01;
        expect_sweep(0, 8'd64, model_sig(3, 3'd1));
        @(negedge clk); bus3.ui_in = 8'h80;
        wait_done(0, 200);
        settle();
        snap(0, "w3_sweep_and_after_reset", model_sig(3, 3'd1), 8'h48);

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0 || done_exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover_expectations: snap=%0d sweep=%0d, want 0", exp_q.size(), done_exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
